debouncer: RTL and testbench

Cleans up one raw, asynchronous, bouncing input (push-button, switch, external strobe) before it reaches the edge-detector stage. It synchronises the input into the `clk` domain and qualifies each level change with a stable-time counter. It drives a clean level whose transitions are single, glitch-free, and fully synchronous, so the downstream edge detector produces exactly one rising or falling pulse per real transition.

---
 rtl/debouncer_pkg.sv | 11 +
 rtl/sync_ff.sv | 25 ++
 rtl/debouncer.sv | 101 ++++++++++
 tb/tb_debouncer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// Shared types for the debouncer: the qualification FSM state encoding.
package debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LO,
    CHECK_HI,
    IDLE_HI,
    CHECK_LO
  } debounce_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; reusable for any
// raw input crossing into the clk domain.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Synchronises a bouncing input and accepts a level change only after
// STABLE_CYCLES consecutive synchronised samples at the new level.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic a_i,
  output logic db_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam debounce_state_t RESET_STATE = RESET_LEVEL ? IDLE_HI : IDLE_LO;

  logic             s;
  debounce_state_t  state;
  logic [CNT_W-1:0] cnt;

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(RESET_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (a_i),
    .q_o  (s)
  );

  // The first opposite sample counts as one, so acceptance lands on the
  // STABLE_CYCLES-th consecutive sample and cnt never passes CNT_LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RESET_STATE;
      cnt    <= '0;
      db_o   <= RESET_LEVEL;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE_LO: begin
          if (s) begin
            state  <= CHECK_HI;
            cnt    <= CNT_W'(1);
            busy_o <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        CHECK_HI: begin
          if (!s) begin
            state  <= IDLE_LO;
            cnt    <= '0;
            busy_o <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE_HI;
            cnt    <= '0;
            db_o   <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state  <= CHECK_LO;
            cnt    <= CNT_W'(1);
            busy_o <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        CHECK_LO: begin
          if (s) begin
            state  <= IDLE_HI;
            cnt    <= '0;
            busy_o <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE_LO;
            cnt    <= '0;
            db_o   <= 1'b0;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= RESET_STATE;
          cnt    <= '0;
          db_o   <= RESET_LEVEL;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer: a run-length reference model queues the
// expected {db_o, busy_o} after every edge; each scenario pops and compares.
module tb_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic reset;
  logic a_i;
  logic db_o;
  logic busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] sb[$];

  always #5 clk = ~clk;

  debouncer #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a_i   (a_i),
    .db_o  (db_o),
    .busy_o(busy_o)
  );

  // Reference model: delay a_i by SYNC samples, count consecutive samples
  // differing from the accepted level, flip once the run reaches STABLE.
  logic [SYNC-1:0] m_sq;
  logic            m_db;
  int              m_run;
  logic            m_db_n;
  int              m_run_n;

  always_comb begin
    m_db_n  = m_db;
    m_run_n = 0;
    if (m_sq[SYNC-1] != m_db) begin
      if (m_run + 1 == STABLE) begin
        m_db_n  = ~m_db;
        m_run_n = 0;
      end else begin
        m_run_n = m_run + 1;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sq  <= '0;
      m_db  <= 1'b0;
      m_run <= 0;
      sb.delete();
    end else begin
      m_sq  <= {m_sq[SYNC-2:0], a_i};
      m_db  <= m_db_n;
      m_run <= m_run_n;
      sb.push_back({m_db_n, (m_run_n != 0)});
    end
  end

  // Downstream edge detector fed by db_o.
  logic db_q;
  logic rise_pulse;
  logic fall_pulse;
  always @(posedge clk or posedge reset) begin
    if (reset) db_q <= 1'b0;
    else       db_q <= db_o;
  end
  assign rise_pulse = db_o & ~db_q;
  assign fall_pulse = ~db_o & db_q;

  task automatic test_reset();
    logic [1:0] want;
    reset = 1'b1;
    a_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (db_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: db=%b busy=%b required 0 0", i, db_o, busy_o);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL reset_release sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want) begin
          n_fail++;
          $display("FAIL reset_release cyc %0d: db,busy=%b required %b", i, {db_o, busy_o}, want);
        end
      end
      if (i == 4 || i == 5) begin
        n_checks++;
        if (db_o !== (i == 5)) begin
          n_fail++;
          $display("FAIL reset_release_latency cyc %0d: db=%b required %b", i, db_o, (i == 5));
        end
      end
    end
  endtask

  task automatic test_clean_fall();
    logic [1:0] want;
    a_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL clean_fall sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want) begin
          n_fail++;
          $display("FAIL clean_fall cyc %0d: db,busy=%b required %b", i, {db_o, busy_o}, want);
        end
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [1:0] want;
    a_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL clean_rise sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want) begin
          n_fail++;
          $display("FAIL clean_rise cyc %0d: db,busy=%b required %b", i, {db_o, busy_o}, want);
        end
      end
      if (i == 1 || i == 2) begin
        n_checks++;
        if (busy_o !== (i == 2)) begin
          n_fail++;
          $display("FAIL clean_rise_busy cyc %0d: busy=%b required %b", i, busy_o, (i == 2));
        end
      end
      if (i == 4 || i == 5) begin
        n_checks++;
        if (db_o !== (i == 5) || (i == 5 && busy_o !== 1'b0)) begin
          n_fail++;
          $display("FAIL clean_rise_accept cyc %0d: db=%b busy=%b required db=%b", i, db_o, busy_o, (i == 5));
        end
      end
    end
  endtask

  task automatic test_reset_mid_check();
    logic [1:0] want;
    a_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL mid_check sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want) begin
          n_fail++;
          $display("FAIL mid_check cyc %0d: db,busy=%b required %b", i, {db_o, busy_o}, want);
        end
      end
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (db_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_check_async_reset: db=%b busy=%b required 0 0", db_o, busy_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL mid_check_release sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want || db_o !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_check_release cyc %0d: db,busy=%b required %b, db 0", i, {db_o, busy_o}, want);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] want;
    logic saw_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_i = (i < 2);
      @(posedge clk); #1;
      if (busy_o === 1'b1) saw_busy = 1'b1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL glitch sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want || db_o !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch cyc %0d: db,busy=%b required %b, db 0", i, {db_o, busy_o}, want);
        end
      end
    end
    n_checks++;
    if (saw_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_pulse: saw busy=%b required 1", saw_busy);
    end
  endtask

  task automatic test_subcycle_pulse();
    logic [1:0] want;
    #2 a_i = 1'b1;
    #3 a_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL subcycle sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want || {db_o, busy_o} !== 2'b00) begin
          n_fail++;
          $display("FAIL subcycle cyc %0d: db,busy=%b required %b, 00", i, {db_o, busy_o}, want);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0]  want;
    logic [14:0] pat = 15'b111_1111_1111_0101;
    logic        prev = db_o;
    int          rises = 0;
    int          rise_at = -1;
    for (int i = 0; i < 15; i++) begin
      a_i = pat[i];
      @(posedge clk); #1;
      if (db_o === 1'b1 && prev === 1'b0) begin
        rises++;
        rise_at = i;
      end
      prev = db_o;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL bounce sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want) begin
          n_fail++;
          $display("FAIL bounce cyc %0d: db,busy=%b required %b", i, {db_o, busy_o}, want);
        end
      end
    end
    n_checks++;
    if (rises != 1 || rise_at != 9) begin
      n_fail++;
      $display("FAIL bounce_single_rise: rises=%0d at cyc %0d required 1 at cyc 9", rises, rise_at);
    end
  endtask

  task automatic test_chained_edges();
    logic [1:0]  want;
    logic [11:0] press = 12'b1111_1111_0101;
    int          rises = 0;
    int          falls = 0;
    for (int i = 0; i < 8 + 5 * 24; i++) begin
      if (i < 8)                     a_i = 1'b0;
      else if (((i - 8) % 24) < 12)  a_i = press[(i - 8) % 24];
      else                           a_i = ~press[((i - 8) % 24) - 12];
      @(posedge clk); #1;
      if (i >= 8) begin
        if (rise_pulse === 1'b1) rises++;
        if (fall_pulse === 1'b1) falls++;
      end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL chained sb empty cyc %0d", i);
      end else begin
        want = sb.pop_front();
        if ({db_o, busy_o} !== want) begin
          n_fail++;
          $display("FAIL chained cyc %0d: db,busy=%b required %b", i, {db_o, busy_o}, want);
        end
      end
    end
    n_checks++;
    if (rises != 5 || falls != 5) begin
      n_fail++;
      $display("FAIL chained_pulse_count: rises=%0d falls=%0d required 5 5", rises, falls);
    end
  endtask

  initial begin
    test_reset();
    test_clean_fall();
    test_clean_rise();
    test_reset_mid_check();
    test_glitch();
    test_subcycle_pulse();
    test_bounce();
    test_chained_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
